// File: rtl/periph_resp_pkg.sv
// periph_resp_pkg: shared constants and helpers for the peripheral response scheduler.
package periph_resp_pkg;
    localparam int SRC0 = 0;
    localparam int SRC1 = 1;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/periph_resp_scheduler_if.sv
// periph_resp_scheduler_if: two source response streams in, two collision-free scheduled streams and status out.
interface periph_resp_scheduler_if #(parameter int DATA_WIDTH = 32);
    logic [1:0][DATA_WIDTH-1:0] src_rdata;
    logic [1:0]                 src_valid;
    logic [1:0]                 src_opc;
    logic [1:0][DATA_WIDTH-1:0] sch_rdata;
    logic [1:0]                 sch_valid;
    logic [1:0]                 sch_opc;
    logic [1:0]                 full;
    logic                       overflow;

    modport master(
        output src_rdata, src_valid, src_opc,
        input  sch_rdata, sch_valid, sch_opc, full, overflow
    );
    modport slave(
        input  src_rdata, src_valid, src_opc,
        output sch_rdata, sch_valid, sch_opc, full, overflow
    );
endinterface

// File: rtl/periph_resp_fifo.sv
// periph_resp_fifo: small circular FIFO with combinational head; push and pop may coincide even when full.
module periph_resp_fifo
    import periph_resp_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end

    // When full with push+pop, the write lands on the slot being popped; head is read before the edge.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/periph_resp_scheduler.sv
// periph_resp_scheduler: buffers colliding source responses and issues at most one per cycle, round-robin, registered.
module periph_resp_scheduler
    import periph_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    periph_resp_scheduler_if.slave bus
);
    localparam int W  = DATA_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0][W-1:0] head, cand_data;
    logic [CW-1:0]     occ [2];
    logic [1:0]        empty, fifo_full, cand, grant, pop, push_req, push, drop;
    logic              rr_q;

    for (genvar k = 0; k < 2; k++) begin : g_src
        assign cand[k]      = !empty[k] || bus.src_valid[k];
        assign cand_data[k] = empty[k] ? {bus.src_opc[k], bus.src_rdata[k]} : head[k];
        assign pop[k]       = grant[k] && !empty[k];
        // A response granted straight from the input never enters its FIFO.
        assign push_req[k]  = bus.src_valid[k] && !(empty[k] && grant[k]);
        assign drop[k]      = push_req[k] && (occ[k] == CW'(FIFO_DEPTH)) && !pop[k];
        assign push[k]      = push_req[k] && !drop[k];

        periph_resp_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   ({bus.src_opc[k], bus.src_rdata[k]}),
            .head  (head[k]),
            .empty (empty[k]),
            .full  (fifo_full[k]),
            .count (occ[k])
        );
    end

    assign grant[SRC0] = cand[SRC0] && (!cand[SRC1] || rr_q == 1'(SRC0));
    assign grant[SRC1] = cand[SRC1] && (!cand[SRC0] || rr_q == 1'(SRC1));
    assign bus.full    = fifo_full;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rr_q          <= 1'b0;
            bus.sch_valid <= '0;
            bus.sch_rdata <= '0;
            bus.sch_opc   <= '0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.sch_valid <= grant;
            for (int i = 0; i < 2; i++)
                if (grant[i]) {bus.sch_opc[i], bus.sch_rdata[i]} <= cand_data[i];
            if (|grant) rr_q <= grant[SRC0];
            bus.overflow <= bus.overflow || (|drop);
        end
endmodule

// File: tb/tb_periph_resp_scheduler.sv
// tb_periph_resp_scheduler: directed table, corner sequences and random traffic on depth-2 and depth-4 instances,
// checked against a queue-based reference model.
module tb_periph_resp_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    periph_resp_scheduler_if #(.DATA_WIDTH(32)) bus2 ();
    periph_resp_scheduler_if #(.DATA_WIDTH(32)) bus4 ();

    periph_resp_scheduler #(.DATA_WIDTH(32), .FIFO_DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    periph_resp_scheduler #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int n_chk = 0;
    int n_fail = 0;

    logic [1:0]       in_v;
    logic [1:0][31:0] in_d;
    logic [1:0]       in_o;

    // Reference model: one queue per (instance, source), flattened as inst*2+src.
    int          depth [2] = '{2, 4};
    logic [32:0] mq [4][$];
    bit          m_rr [2];
    logic [1:0]  m_v [2];
    logic [31:0] m_d [2][2];
    logic [1:0]  m_o [2];
    bit          m_ovf [2];

    typedef struct {
        logic [1:0]  v;
        logic [31:0] d0, d1;
        logic [1:0]  o;
        logic [1:0]  ev;
        logic [31:0] ed0, ed1;
        logic [1:0]  eo;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bus2.src_valid = in_v; bus2.src_rdata = in_d; bus2.src_opc = in_o;
        bus4.src_valid = in_v; bus4.src_rdata = in_d; bus4.src_opc = in_o;
    endtask

    task automatic model_clear();
        for (int q = 0; q < 4; q++) mq[q].delete();
        for (int i = 0; i < 2; i++) begin
            m_rr[i] = 0; m_v[i] = '0; m_o[i] = '0; m_ovf[i] = 0;
            m_d[i][0] = '0; m_d[i][1] = '0;
        end
    endtask

    task automatic model_step(input int i);
        bit          was_empty [2];
        bit          has [2];
        bit          g [2];
        logic [32:0] c [2];
        for (int k = 0; k < 2; k++) begin
            was_empty[k] = (mq[i*2+k].size() == 0);
            has[k] = !was_empty[k] || in_v[k];
            c[k] = was_empty[k] ? {in_o[k], in_d[k]} : mq[i*2+k][0];
        end
        g[0] = has[0] && (!has[1] || !m_rr[i]);
        g[1] = has[1] && (!has[0] || m_rr[i]);
        for (int k = 0; k < 2; k++) begin
            if (g[k] && !was_empty[k]) mq[i*2+k].delete(0);
            if (in_v[k] && !(g[k] && was_empty[k])) begin
                if (mq[i*2+k].size() < depth[i]) mq[i*2+k].push_back({in_o[k], in_d[k]});
                else m_ovf[i] = 1;
            end
            m_v[i][k] = g[k];
            if (g[k]) begin
                m_o[i][k] = c[k][32];
                m_d[i][k] = c[k][31:0];
            end
        end
        if (g[0]) m_rr[i] = 1;
        else if (g[1]) m_rr[i] = 0;
    endtask

    task automatic cmp_inst(input int i, input logic [1:0] v, input logic [1:0][31:0] d,
                            input logic [1:0] o, input logic [1:0] f, input logic ovf);
        logic [1:0] ef;
        ef = {mq[i*2+1].size() == depth[i], mq[i*2].size() == depth[i]};
        chk($sformatf("d%0d_valid", depth[i]), v, m_v[i]);
        chk($sformatf("d%0d_both_valid", depth[i]), v[0] & v[1], 0);
        chk($sformatf("d%0d_rdata0", depth[i]), d[0], m_d[i][0]);
        chk($sformatf("d%0d_rdata1", depth[i]), d[1], m_d[i][1]);
        chk($sformatf("d%0d_opc", depth[i]), o, m_o[i]);
        chk($sformatf("d%0d_full", depth[i]), f, ef);
        chk($sformatf("d%0d_overflow", depth[i]), ovf, m_ovf[i]);
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] o);
        in_v = v; in_d[0] = d0; in_d[1] = d1; in_o = o;
        drive();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cmp_inst(0, bus2.sch_valid, bus2.sch_rdata, bus2.sch_opc, bus2.full, bus2.overflow);
        cmp_inst(1, bus4.sch_valid, bus4.sch_rdata, bus4.sch_opc, bus4.full, bus4.overflow);
    endtask

    task automatic do_reset();
        in_v = '0; in_d = '0; in_o = '0;
        drive();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{2'b00, 32'h0,        32'h0,  2'b00, 2'b00, 32'h0,        32'h0,  2'b00};
        tbl[1] = '{2'b11, 32'hA0,       32'hB1, 2'b00, 2'b01, 32'hA0,       32'h0,  2'b00};
        tbl[2] = '{2'b00, 32'h0,        32'h0,  2'b00, 2'b10, 32'hA0,       32'hB1, 2'b00};
        tbl[3] = '{2'b00, 32'h0,        32'h0,  2'b00, 2'b00, 32'hA0,       32'hB1, 2'b00};
        tbl[4] = '{2'b01, 32'hDEADBEEF, 32'h0,  2'b00, 2'b01, 32'hDEADBEEF, 32'hB1, 2'b00};
        tbl[5] = '{2'b00, 32'h0,        32'h0,  2'b00, 2'b00, 32'hDEADBEEF, 32'hB1, 2'b00};
        tbl[6] = '{2'b10, 32'h0,        32'h55, 2'b10, 2'b10, 32'hDEADBEEF, 32'h55, 2'b10};

        do_reset();
        chk("reset_valid", bus2.sch_valid, 0);
        chk("reset_rdata", bus2.sch_rdata, 0);
        chk("reset_full", bus2.full, 0);
        chk("reset_overflow", bus2.overflow, 0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].o);
            chk($sformatf("tbl%0d_valid", i), bus2.sch_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_rdata0", i), bus2.sch_rdata[0], tbl[i].ed0);
            chk($sformatf("tbl%0d_rdata1", i), bus2.sch_rdata[1], tbl[i].ed1);
            chk($sformatf("tbl%0d_opc", i), bus2.sch_opc, tbl[i].eo);
            chk($sformatf("tbl%0d_full", i), bus2.full, 0);
        end

        // Round-robin: four colliding cycles drain strictly alternating, in per-source order.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(i < 4 ? 2'b11 : 2'b00, 32'(i), 32'(32'h10 + i), 2'b00);
            chk("rr_stream", bus4.sch_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_data", bus4.sch_rdata[i%2], (i % 2 == 0) ? 32'(i / 2) : 32'(32'h10 + i / 2));
        end
        chk("rr_overflow", bus4.overflow, 0);

        // Overflow on the depth-2 instance under sustained collisions.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 32'(32'h100 + i), 32'(32'h200 + i), 2'b00);
            if (i == 2) chk("ovf_full_set", |bus2.full, 1);
            if (i == 3) chk("ovf_before_drop", bus2.overflow, 0);
            if (i >= 4) chk("ovf_sticky", bus2.overflow, 1);
        end
        for (int i = 0; i < 6; i++) step(2'b00, 0, 0, 2'b00);
        chk("ovf_after_drain", bus2.overflow, 1);

        // Full FIFO1 with its head granted while a new src1 response arrives.
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b11, 32'(32'h300 + i), 32'(32'h400 + i), 2'b00);
        chk("pp_full_before", bus2.full, 2'b10);
        step(2'b10, 0, 32'h403, 2'b00);
        chk("pp_granted_src1", bus2.sch_valid, 2'b10);
        chk("pp_full_after", bus2.full, 2'b10);
        chk("pp_no_overflow", bus2.overflow, 0);
        for (int i = 0; i < 5; i++) step(2'b00, 0, 0, 2'b00);

        // Asynchronous reset with three responses buffered.
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b11, 32'(32'h500 + i), 32'(32'h600 + i), 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", bus2.sch_valid, 0);
        chk("arst_rdata", bus2.sch_rdata, 0);
        chk("arst_opc", bus2.sch_opc, 0);
        chk("arst_full", bus2.full, 0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(2'b00, 0, 0, 2'b00);
            chk("arst_no_pulse", bus2.sch_valid | bus4.sch_valid, 0);
        end

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++)
            step({1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 35)},
                 $urandom, $urandom, 2'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
